// File: rtl/bank_switch_pkg.sv
// bank_switch_pkg
//   Shared types and helpers for the multi-channel frame-buffer bank switch.
//   - wr_state_e / rd_state_e : writer and reader FSM states
//   - next_bank()             : next write bank, skipping the bank the reader holds
//   - params_ok()             : legal parameter ranges for the top level
package bank_switch_pkg;

  typedef enum logic {W_IDLE, W_BUSY} wr_state_e;
  typedef enum logic {R_IDLE, R_RUN}  rd_state_e;

  localparam int MIN_CH    = 1;
  localparam int MAX_CH    = 8;
  localparam int MIN_BANKS = 3;
  localparam int MAX_BANKS = 8;

  // With at least three banks, stepping by two always clears both the bank
  // just written and the bank the reader is on.
  function automatic int next_bank(input int cur, input int rd, input int num_banks);
    int nb;
    nb = (cur + 1) % num_banks;
    if (nb == rd) nb = (cur + 2) % num_banks;
    return nb;
  endfunction

  function automatic bit params_ok(input int num_ch, input int num_banks, input int cnt_w);
    return (num_ch >= MIN_CH) && (num_ch <= MAX_CH) &&
           (num_banks >= MIN_BANKS) && (num_banks <= MAX_BANKS) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/multi_bank_switch_if.sv
// multi_bank_switch_if
//   Bundle between the slave/DDR-FIFO side and the bank switch.
//   Channel i uses bit i of 1-bit vectors and slice [i*BANK_W +: BANK_W]
//   of bank vectors (and [i*CNT_W +: CNT_W] of the counters).
//   master : drives ch_en, slave_valid, frame_wr_done, frame_rd_done
//   slave  : drives wr_load, wr_bank, rd_load, rd_bank (+ drop_cnt, rep_cnt)
//   Optional: BANK_STATS_EN adds the drop_cnt / rep_cnt counters.
interface multi_bank_switch_if #(
  parameter int NUM_CH = 4,
  parameter int BANK_W = 2
`ifdef BANK_STATS_EN
  , parameter int CNT_W = 16
`endif
) ();
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        slave_valid;
  logic [NUM_CH-1:0]        frame_wr_done;
  logic [NUM_CH-1:0]        frame_rd_done;
  logic [NUM_CH-1:0]        wr_load;
  logic [NUM_CH*BANK_W-1:0] wr_bank;
  logic [NUM_CH-1:0]        rd_load;
  logic [NUM_CH*BANK_W-1:0] rd_bank;
`ifdef BANK_STATS_EN
  logic [NUM_CH*CNT_W-1:0]  drop_cnt;
  logic [NUM_CH*CNT_W-1:0]  rep_cnt;
`endif

  modport master (
    output ch_en, slave_valid, frame_wr_done, frame_rd_done,
    input  wr_load, wr_bank, rd_load, rd_bank
`ifdef BANK_STATS_EN
    , input drop_cnt, rep_cnt
`endif
  );

  modport slave (
    input  ch_en, slave_valid, frame_wr_done, frame_rd_done,
    output wr_load, wr_bank, rd_load, rd_bank
`ifdef BANK_STATS_EN
    , output drop_cnt, rep_cnt
`endif
  );
endinterface

// File: rtl/bank_switch_ch.sv
// bank_switch_ch
//   One channel of the bank switch: writer FSM, reader FSM, bank registers.
//   Inputs : ddr_clk, sys_rstn (async, active-low), ch_en, slave_valid,
//            frame_wr_done, frame_rd_done
//   Outputs: wr_load, wr_bank, rd_load, rd_bank (all registered)
//            drop_cnt, rep_cnt with BANK_STATS_EN defined
module bank_switch_ch
  import bank_switch_pkg::*;
#(
  parameter  int NUM_BANKS = 4,
`ifdef BANK_STATS_EN
  parameter  int CNT_W     = 16,
`endif
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              ddr_clk,
  input  logic              sys_rstn,
  input  logic              ch_en,
  input  logic              slave_valid,
  input  logic              frame_wr_done,
  input  logic              frame_rd_done,
  output logic              wr_load,
  output logic [BANK_W-1:0] wr_bank,
  output logic              rd_load,
  output logic [BANK_W-1:0] rd_bank
`ifdef BANK_STATS_EN
  , output logic [CNT_W-1:0] drop_cnt
  , output logic [CNT_W-1:0] rep_cnt
`endif
);

  wr_state_e         w_state;
  rd_state_e         r_state;
  logic              sv_p0, sv_p1;
  logic [BANK_W-1:0] latest;
  logic              fresh;

  logic              rise;
  logic              wr_acc;
  logic              fresh_w;
  logic [BANK_W-1:0] latest_w;
  logic              rd_take;
  logic              rd_rep;
  logic [BANK_W-1:0] rd_next;
  logic [BANK_W-1:0] wr_next;

  // The writer completion is folded in first (fresh_w/latest_w), so a reader
  // event in the same cycle grabs the bank that just finished, and the next
  // write bank is chosen against the reader's updated bank.
  always_comb begin
    rise     = sv_p0 & ~sv_p1;
    wr_acc   = ch_en && (w_state == W_BUSY) && frame_wr_done;
    fresh_w  = wr_acc | fresh;
    latest_w = wr_acc ? wr_bank : latest;
    rd_take  = ch_en && (((r_state == R_IDLE) && fresh) ||
                         ((r_state == R_RUN) && frame_rd_done && fresh_w));
    rd_rep   = ch_en && (r_state == R_RUN) && frame_rd_done && !fresh_w;
    rd_next  = rd_take ? latest_w : rd_bank;
    wr_next  = wr_acc ? BANK_W'(next_bank(int'(wr_bank), int'(rd_next), NUM_BANKS)) : wr_bank;
  end

  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sv_p0   <= 1'b0;
      sv_p1   <= 1'b0;
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      wr_load <= 1'b0;
      rd_load <= 1'b0;
      wr_bank <= '0;
      rd_bank <= BANK_W'(NUM_BANKS - 1);
      latest  <= BANK_W'(NUM_BANKS - 1);
      fresh   <= 1'b0;
    end else begin
      // p0: sample slave_valid; p1: previous sample for edge detection
      sv_p0   <= slave_valid;
      sv_p1   <= sv_p0;
      wr_load <= 1'b0;
      rd_load <= 1'b0;
      if (!ch_en) begin
        w_state <= W_IDLE;
        r_state <= R_IDLE;
        fresh   <= 1'b0;
      end else begin
        wr_bank <= wr_next;
        rd_bank <= rd_next;
        latest  <= latest_w;
        fresh   <= fresh_w & ~rd_take;
        case (w_state)
          W_IDLE: if (rise) begin
            w_state <= W_BUSY;
            wr_load <= 1'b1;
          end
          W_BUSY: begin
            // A new edge either restarts an aborted frame or, together with
            // a completion, starts the next frame in the new bank.
            wr_load <= rise;
            if (wr_acc && !rise) w_state <= W_IDLE;
          end
        endcase
        case (r_state)
          R_IDLE: if (rd_take) begin
            r_state <= R_RUN;
            rd_load <= 1'b1;
          end
          R_RUN: if (frame_rd_done) rd_load <= 1'b1;
        endcase
      end
    end
  end

`ifdef BANK_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      drop_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      if (wr_acc && fresh) drop_cnt <= sat_inc(drop_cnt);
      if (rd_rep)          rep_cnt  <= sat_inc(rep_cnt);
    end
  end
`endif

endmodule

// File: rtl/multi_bank_switch.sv
// multi_bank_switch
//   NUM_CH-channel, NUM_BANKS-deep frame-buffer bank arbiter (ddr_clk domain).
//   Ports: ddr_clk, sys_rstn (async, active-low), bus (multi_bank_switch_if.slave)
//   Optional: BANK_STATS_EN adds per-channel drop_cnt / rep_cnt counters.
module multi_bank_switch
  import bank_switch_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int NUM_BANKS = 4,
  parameter  int CNT_W     = 16,
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input logic                 ddr_clk,
  input logic                 sys_rstn,
  multi_bank_switch_if.slave  bus
);

  if (!params_ok(NUM_CH, NUM_BANKS, CNT_W)) begin : g_bad_params
    $error("multi_bank_switch: NUM_CH must be 1..8, NUM_BANKS 3..8, CNT_W >= 1");
  end

  logic [NUM_CH-1:0]        wr_load_w;
  logic [NUM_CH-1:0]        rd_load_w;
  logic [NUM_CH*BANK_W-1:0] wr_bank_w;
  logic [NUM_CH*BANK_W-1:0] rd_bank_w;
`ifdef BANK_STATS_EN
  logic [NUM_CH*CNT_W-1:0]  drop_w;
  logic [NUM_CH*CNT_W-1:0]  rep_w;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bank_switch_ch #(
      .NUM_BANKS (NUM_BANKS)
`ifdef BANK_STATS_EN
      , .CNT_W   (CNT_W)
`endif
    ) u_ch (
      .ddr_clk       (ddr_clk),
      .sys_rstn      (sys_rstn),
      .ch_en         (bus.ch_en[i]),
      .slave_valid   (bus.slave_valid[i]),
      .frame_wr_done (bus.frame_wr_done[i]),
      .frame_rd_done (bus.frame_rd_done[i]),
      .wr_load       (wr_load_w[i]),
      .wr_bank       (wr_bank_w[i*BANK_W +: BANK_W]),
      .rd_load       (rd_load_w[i]),
      .rd_bank       (rd_bank_w[i*BANK_W +: BANK_W])
`ifdef BANK_STATS_EN
      , .drop_cnt    (drop_w[i*CNT_W +: CNT_W])
      , .rep_cnt     (rep_w[i*CNT_W +: CNT_W])
`endif
    );
  end

  assign bus.wr_load = wr_load_w;
  assign bus.rd_load = rd_load_w;
  assign bus.wr_bank = wr_bank_w;
  assign bus.rd_bank = rd_bank_w;
`ifdef BANK_STATS_EN
  assign bus.drop_cnt = drop_w;
  assign bus.rep_cnt  = rep_w;
`endif

endmodule

// File: tb/tb_multi_bank_switch.sv
// tb_multi_bank_switch
//   Bench for multi_bank_switch: a 4-channel/4-bank instance and a
//   1-channel/3-bank instance, checked against a frame-level reference model
//   every cycle, plus a reset/first-frame vector table and directed sequences.
//   Counter checks are active when BANK_STATS_EN is defined.
module tb_multi_bank_switch;

  localparam int BW = 2;
  localparam int NM = 5;   // model slots: 0..3 = big instance, 4 = 3-bank instance

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  multi_bank_switch_if #(.NUM_CH(4), .BANK_W(BW)
`ifdef BANK_STATS_EN
    , .CNT_W(16)
`endif
  ) bus ();
  multi_bank_switch_if #(.NUM_CH(1), .BANK_W(BW)
`ifdef BANK_STATS_EN
    , .CNT_W(16)
`endif
  ) bus3 ();

  multi_bank_switch #(.NUM_CH(4), .NUM_BANKS(4), .CNT_W(16)) dut (
    .ddr_clk(clk), .sys_rstn(rstn), .bus(bus));
  multi_bank_switch #(.NUM_CH(1), .NUM_BANKS(3), .CNT_W(16)) dut3 (
    .ddr_clk(clk), .sys_rstn(rstn), .bus(bus3));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Frame-level reference state per channel
  int m_nb[NM], m_wr[NM], m_rd[NM], m_lat[NM], m_drop[NM], m_rep[NM];
  bit m_writing[NM], m_reading[NM], m_fresh[NM], m_s1[NM], m_s2[NM], m_wl[NM], m_rl[NM];

  int prev_w3 = 0;
  bit seen_wrap = 0;

  typedef struct {
    bit v; bit wd; bit rdn;
    bit wl; int wb; bit rl; int rb;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic void get_in(input int m, output bit en, output bit v, output bit wd, output bit rdn);
    if (m < 4) begin
      en = bus.ch_en[m]; v = bus.slave_valid[m]; wd = bus.frame_wr_done[m]; rdn = bus.frame_rd_done[m];
    end else begin
      en = bus3.ch_en[0]; v = bus3.slave_valid[0]; wd = bus3.frame_wr_done[0]; rdn = bus3.frame_rd_done[0];
    end
  endfunction

  // One clock of the channel, following the frame rules: a finished write
  // publishes its bank as the newest frame; the reader always moves to the
  // newest unread frame or repeats; the writer moves to the next bank the
  // reader is not using.
  function automatic void model_step(input int m);
    bit en, v, wd, rdn, edge_seen, was_fresh, finished;
    get_in(m, en, v, wd, rdn);
    edge_seen = m_s1[m] && !m_s2[m];
    was_fresh = m_fresh[m];
    finished  = 1'b0;
    m_wl[m] = 1'b0;
    m_rl[m] = 1'b0;
    if (!en) begin
      m_writing[m] = 1'b0; m_reading[m] = 1'b0; m_fresh[m] = 1'b0;
    end else begin
      if (m_writing[m] && wd) begin
        finished = 1'b1;
        if (m_fresh[m]) m_drop[m] = (m_drop[m] < 65535) ? m_drop[m] + 1 : 65535;
        m_lat[m] = m_wr[m];
        m_fresh[m] = 1'b1;
        m_writing[m] = 1'b0;
      end
      if (!m_reading[m]) begin
        if (was_fresh) begin
          m_reading[m] = 1'b1; m_rd[m] = m_lat[m]; m_fresh[m] = 1'b0; m_rl[m] = 1'b1;
        end
      end else if (rdn) begin
        if (m_fresh[m]) begin
          m_rd[m] = m_lat[m]; m_fresh[m] = 1'b0;
        end else begin
          m_rep[m] = (m_rep[m] < 65535) ? m_rep[m] + 1 : 65535;
        end
        m_rl[m] = 1'b1;
      end
      if (finished) begin
        m_wr[m] = (m_wr[m] + 1) % m_nb[m];
        if (m_wr[m] == m_rd[m]) m_wr[m] = (m_wr[m] + 1) % m_nb[m];
      end
      if (edge_seen) begin
        m_writing[m] = 1'b1; m_wl[m] = 1'b1;
      end
    end
    m_s2[m] = m_s1[m];
    m_s1[m] = v;
  endfunction

  function automatic int wbk(input int m);
    if (m < 4) return int'(bus.wr_bank[m*BW +: BW]);
    return int'(bus3.wr_bank[BW-1:0]);
  endfunction
  function automatic int rbk(input int m);
    if (m < 4) return int'(bus.rd_bank[m*BW +: BW]);
    return int'(bus3.rd_bank[BW-1:0]);
  endfunction
  function automatic int outs(input int m);
    int wl, rl;
    wl = (m < 4) ? int'(bus.wr_load[m]) : int'(bus3.wr_load[0]);
    rl = (m < 4) ? int'(bus.rd_load[m]) : int'(bus3.rd_load[0]);
    return 1000*wl + 100*wbk(m) + 10*rl + rbk(m);
  endfunction

  task automatic cyc();
    @(posedge clk);
    for (int m = 0; m < NM; m++) model_step(m);
    #1;
    cyc_n++;
    for (int m = 0; m < NM; m++) begin
      chk($sformatf("model ch%0d {wl,wb,rl,rb}", m), outs(m),
          1000*int'(m_wl[m]) + 100*m_wr[m] + 10*int'(m_rl[m]) + m_rd[m]);
      if (m_writing[m] && m_reading[m])
        chk($sformatf("bank clash ch%0d", m), int'(wbk(m) != rbk(m)), 1);
`ifdef BANK_STATS_EN
      if (m < 4) begin
        chk($sformatf("drop_cnt ch%0d", m), int'(bus.drop_cnt[m*16 +: 16]), m_drop[m]);
        chk($sformatf("rep_cnt ch%0d", m), int'(bus.rep_cnt[m*16 +: 16]), m_rep[m]);
      end
`endif
    end
    if (prev_w3 == 2 && wbk(4) == 0) seen_wrap = 1'b1;
    prev_w3 = wbk(4);
  endtask

  task automatic frame(input int m);
    bus.slave_valid[m] = 1'b1;
    cyc();
    cyc();
    chk($sformatf("wr_load ch%0d", m), int'(bus.wr_load[m]), 1);
    bus.slave_valid[m] = 1'b0;
    cyc();
  endtask
  task automatic wdone(input int m);
    bus.frame_wr_done[m] = 1'b1;
    cyc();
    bus.frame_wr_done[m] = 1'b0;
  endtask
  task automatic rdone(input int m);
    bus.frame_rd_done[m] = 1'b1;
    cyc();
    bus.frame_rd_done[m] = 1'b0;
  endtask

  initial begin
    bus.ch_en = '1; bus.slave_valid = '0; bus.frame_wr_done = '0; bus.frame_rd_done = '0;
    bus3.ch_en = '1; bus3.slave_valid = '0; bus3.frame_wr_done = '0; bus3.frame_rd_done = '0;
    for (int m = 0; m < NM; m++) begin
      m_nb[m] = (m < 4) ? 4 : 3;
      m_wr[m] = 0; m_rd[m] = m_nb[m] - 1; m_lat[m] = m_nb[m] - 1;
      m_drop[m] = 0; m_rep[m] = 0;
      m_writing[m] = 0; m_reading[m] = 0; m_fresh[m] = 0; m_s1[m] = 0; m_s2[m] = 0;
      m_wl[m] = 0; m_rl[m] = 0;
    end
    //          v  wd rd   wl wb rl rb
    tbl[0] = '{1, 0, 0,   0, 0, 0, 3};
    tbl[1] = '{1, 0, 0,   1, 0, 0, 3};
    tbl[2] = '{1, 0, 0,   0, 0, 0, 3};
    tbl[3] = '{0, 1, 0,   0, 1, 0, 3};
    tbl[4] = '{0, 0, 0,   0, 1, 1, 0};
    tbl[5] = '{0, 0, 0,   0, 1, 0, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < NM; m++)
      chk($sformatf("reset ch%0d {wl,wb,rl,rb}", m), outs(m), (m < 4) ? 3 : 2);
    @(negedge clk);
    rstn = 1'b1;

    // Reset and first frame on ch0
    for (int i = 0; i < 6; i++) begin
      bus.slave_valid[0]   = tbl[i].v;
      bus.frame_wr_done[0] = tbl[i].wd;
      bus.frame_rd_done[0] = tbl[i].rdn;
      cyc();
      chk($sformatf("vec%0d wr_load", i), int'(bus.wr_load[0]), int'(tbl[i].wl));
      chk($sformatf("vec%0d wr_bank", i), wbk(0), tbl[i].wb);
      chk($sformatf("vec%0d rd_load", i), int'(bus.rd_load[0]), int'(tbl[i].rl));
      chk($sformatf("vec%0d rd_bank", i), rbk(0), tbl[i].rb);
    end
    bus.frame_wr_done[0] = 1'b0;

    // Walk ch0 to wr_bank=1 / rd_bank=2, then the collision skip
    frame(0); wdone(0); chk("walk wr_bank a", wbk(0), 2);
    frame(0); wdone(0); chk("walk wr_bank b", wbk(0), 3);
    rdone(0);
    chk("walk rd_load", int'(bus.rd_load[0]), 1);
    chk("walk rd_bank", rbk(0), 2);
    frame(0); wdone(0); chk("walk wr_bank c", wbk(0), 0);
    frame(0); wdone(0); chk("walk wr_bank d", wbk(0), 1);
    chk("pre-skip rd_bank", rbk(0), 2);
    frame(0);
    chk("wr_bank stable during frame", wbk(0), 1);
    wdone(0); chk("collision skip wr_bank", wbk(0), 3);

    // Simultaneous completion: wr=3, rd=2
    frame(0);
    bus.frame_wr_done[0] = 1'b1;
    bus.frame_rd_done[0] = 1'b1;
    cyc();
    bus.frame_wr_done[0] = 1'b0;
    bus.frame_rd_done[0] = 1'b0;
    chk("simul rd_load", int'(bus.rd_load[0]), 1);
    chk("simul rd_bank", rbk(0), 3);
    chk("simul wr_bank", wbk(0), 0);

    // Repeat (back-to-back read completions) and drop
    bus.frame_rd_done[0] = 1'b1;
    cyc();
    chk("repeat1 rd_load", int'(bus.rd_load[0]), 1);
    chk("repeat1 rd_bank", rbk(0), 3);
    cyc();
    bus.frame_rd_done[0] = 1'b0;
    chk("repeat2 rd_load", int'(bus.rd_load[0]), 1);
    chk("repeat2 rd_bank", rbk(0), 3);
    frame(0); wdone(0); chk("drop wr_bank a", wbk(0), 1);
    frame(0); wdone(0); chk("drop wr_bank b", wbk(0), 2);
`ifdef BANK_STATS_EN
    chk("rep_cnt ch0 total", int'(bus.rep_cnt[15:0]), 2);
    chk("drop_cnt ch0 total", int'(bus.drop_cnt[15:0]), 5);
`endif

    // Disable ch1 mid-frame while ch0 keeps reading
    frame(1);
    bus.ch_en[1] = 1'b0;
    cyc();
    bus.frame_rd_done[0] = 1'b1;
    bus.frame_wr_done[1] = 1'b1;
    cyc();
    bus.frame_rd_done[0] = 1'b0;
    bus.frame_wr_done[1] = 1'b0;
    bus.slave_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("disabled wr_load", int'(bus.wr_load[1]), 0);
      chk("disabled rd_load", int'(bus.rd_load[1]), 0);
      chk("disabled wr_bank", wbk(1), 0);
    end
    bus.slave_valid[1] = 1'b0;
    cyc(); cyc();
    bus.ch_en[1] = 1'b1;
    cyc();
    frame(1);
    chk("re-enable wr_bank", wbk(1), 0);
    wdone(1);
    chk("re-enable done wr_bank", wbk(1), 1);
    cyc();
    chk("re-enable rd_load", int'(bus.rd_load[1]), 1);
    chk("re-enable rd_bank", rbk(1), 0);

    // Randomised traffic on every channel; the 3-bank instance stays enabled
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 4; m++) begin
        if ($urandom_range(0, 5) == 0) bus.slave_valid[m] = ~bus.slave_valid[m];
        bus.frame_wr_done[m] = ($urandom_range(0, 3) == 0);
        bus.frame_rd_done[m] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 199) == 0) bus.ch_en[m] = ~bus.ch_en[m];
      end
      if ($urandom_range(0, 3) == 0) bus3.slave_valid[0] = ~bus3.slave_valid[0];
      bus3.frame_wr_done[0] = ($urandom_range(0, 1) == 0);
      bus3.frame_rd_done[0] = ($urandom_range(0, 2) == 0);
      cyc();
    end
    chk("3-bank wr_bank wraps 2->0", int'(seen_wrap), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_bank_switch.md
# multi_bank_switch

Parametrised N-channel, N-bank frame-buffer arbiter in the DDR clock domain. It is the successor to the fixed 4-channel, 2-bit bank switch wrapper. Each channel runs triple-or-deeper buffering: writer and reader never share a bank, the reader always takes the newest complete frame, and each channel can be enabled or disabled at run time. It sits between the camera/Ethernet slaves and the DDR write/read FIFOs, which use `wr_bank`/`rd_bank` as the top address bits.

## Interface
- `NUM_CH`, 4, number of slave channels (1..8).
- `NUM_BANKS`, 4, frame buffers per channel (3..8).
- `BANK_W`, derived localparam `$clog2(NUM_BANKS)`, bank index width.
- `CNT_W`, 16, statistics counter width.

Ports (channel `i` occupies slice `[i*BANK_W +: BANK_W]` of bank vectors and bit `i` of 1-bit vectors):
- `ddr_clk` in 1: single clock.
- `sys_rstn` in 1: asynchronous, active-low reset.
- `ch_en` in NUM_CH: per-channel enable.
- `slave_valid` in NUM_CH: new-frame flag (camera vsync level); a rising edge starts a frame.
- `frame_wr_done` in NUM_CH: 1-cycle pulse when a frame write to DDR completes.
- `frame_rd_done` in NUM_CH: 1-cycle pulse when a frame read from DDR completes.
- `wr_load` out NUM_CH: 1-cycle pulse that loads the write address counter.
- `wr_bank` out NUM_CH*BANK_W: current write bank.
- `rd_load` out NUM_CH: 1-cycle pulse that loads the read address counter.
- `rd_bank` out NUM_CH*BANK_W: current read bank.
- `drop_cnt`, `rep_cnt` out NUM_CH*CNT_W: present only with `BANK_STATS_EN`.

## Operation
Per-channel state: `wr_bank`, `rd_bank`, `latest`, `fresh` flag, writer FSM, reader FSM.

- **Reset values:** `wr_bank`=0, `rd_bank`=`latest`=NUM_BANKS-1, `fresh`=0, loads=0, counters=0, FSMs idle.
- **Writer FSM, `W_IDLE`→`W_BUSY`:** a rising edge of registered `slave_valid` triggers the transition and pulses `wr_load`.
- **Writer FSM, `W_BUSY`→`W_IDLE`:** `frame_wr_done` triggers the transition and performs:
  - `latest`←`wr_bank`, `fresh`←1;
  - `wr_bank`←(`wr_bank`+1) mod NUM_BANKS, or +2 if that bank equals the post-update `rd_bank`.
- **Valid edge in `W_BUSY`** (aborted frame): stay in `W_BUSY`, keep the bank, pulse `wr_load` again.
- **`frame_wr_done` in `W_IDLE`:** ignored.
- **Reader FSM, `R_IDLE`→`R_RUN`:** triggered on the first cycle `fresh`=1; `rd_bank`←`latest`, `fresh`←0, pulse `rd_load`.
- **Reader in `R_RUN`, on `frame_rd_done`:**
  - if `fresh`: `rd_bank`←`latest`, `fresh`←0;
  - otherwise `rd_bank` is unchanged (repeat frame);
  - `rd_load` pulses in both cases.
- **Simultaneous `wr_done` and `rd_done`:** the writer update is applied first. The reader takes the just-completed bank, and the writer's next bank is computed against that new `rd_bank`.
- **Invariant:** `wr_bank`≠`rd_bank` whenever both FSMs are active.
- **`ch_en`=0:** both FSMs forced idle, `fresh`←0, banks hold, loads suppressed, pending done pulses dropped. Re-enabling resumes from the held banks.

## Timing
- All outputs are registered.
- `slave_valid` is sampled in cycle N and edge-detected in N+1; `wr_load` is high in cycle N+2.
- `frame_wr_done` in cycle N: new `wr_bank` and `latest` are visible in N+1. A first-frame `rd_load` follows in N+2.
- `frame_rd_done` in cycle N: `rd_load` and the new `rd_bank` are both visible in N+1.
- `wr_bank` is stable on every cycle where `wr_load`=1.
- Channels are fully independent.
- Back-to-back done pulses on consecutive cycles are each processed.

## Configuration
- `BANK_STATS_EN` defined:
  - `drop_cnt[i]` increments when `frame_wr_done` arrives while `fresh`=1 (unread frame overwritten);
  - `rep_cnt[i]` increments when a `R_RUN` `rd_done` arrives with `fresh`=0;
  - both saturate at all-ones and are cleared only by reset.
- Undefined: the counters and their ports are absent, and behaviour is otherwise identical.

## Structure
- Package `bank_switch_pkg`: writer/reader state enums, a `next_bank` function (increment with mod and reader skip), and the parameter range checks.
- Sub-module `bank_switch_ch`: holds one channel's FSMs and registers. It is instantiated `NUM_CH` times by a generate loop in `multi_bank_switch`.

## Test plan
- **Reset and first frame** (NUM_BANKS=4, ch0): release reset, raise valid → `wr_load` 2 cycles later, `wr_bank`=0; `wr_done` → `wr_bank`=1, then `rd_load` with `rd_bank`=0.
- **Reader collision skip:** `rd_bank`=2, `wr_bank`=1, `wr_done` → `wr_bank`=3 (skips 2), `latest`=1.
- **Simultaneous done:** `wr_bank`=3, `rd_bank`=2, both dones in the same cycle → `rd_bank`=3, `wr_bank`=0, `rd_load` next cycle.
- **Repeat and drop:** two `rd_done` with no new frame → `rd_bank` unchanged, `rd_load` twice, `rep_cnt`=2; two `wr_done` with no read → `drop_cnt`=1.
- **Disable mid-frame:** `ch_en[1]`=0 during `W_BUSY` → no loads, `wr_done` ignored. Re-enable + valid → `wr_load`, same `wr_bank`. Other channels unaffected.
- **Parameter sweep:** NUM_BANKS=3, 1000 random dones → `wr_bank`≠`rd_bank` always, and the banks wrap 2→0.
